prt_dp_pm_ldr: RTL and testbench

- Loader/sequencer that fills the policy-maker program RAM from a byte-wide host stream (config bus / AUX bridge).
- Packs bytes into 32-bit words and drives the RAM initialization port (start, data, valid).
- Holds the PM CPU in reset during a load and reports busy, done, error and word count.
- Sits between the host config path and the PM RAM, beside the PM CPU.

---
 rtl/prt_dp_pm_ldr.sv | 189 ++++++++++++++++++
 tb/tb_prt_dp_pm_ldr.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prt_dp_pm_ldr.sv
// prt_dp_pm_ldr -- policy-maker program RAM loader.
// Packs a byte-wide host image into little-endian 32-bit words, drives the
// RAM init port (start, data, valid), holds the PM CPU in reset while a
// load is in progress and reports busy/done/error/word count.
// Optional image checksum check: define PRT_DP_PM_LDR_CHK_EN.
//
// Host byte handshake: a byte transfers on a rising CLK_IN edge where
// HOST_VLD_IN and HOST_RDY_OUT are both high and HOST_STR_IN is low.
// HOST_RDY_OUT is high exactly while the FSM is in LOAD, and the host may
// hold HOST_VLD_IN high across consecutive cycles for back-to-back bytes.
// HOST_STR_IN and HOST_END_IN are single-cycle pulses; HOST_STR_IN wins over
// everything else in the same cycle.

module prt_dp_pm_ldr #(
    parameter int P_ADR = 10
) (
    input  logic             CLK_IN,
    input  logic             RST_IN,
    input  logic             HOST_STR_IN,
    input  logic [7:0]       HOST_DAT_IN,
    input  logic             HOST_VLD_IN,
    output logic             HOST_RDY_OUT,
    input  logic             HOST_END_IN,
    input  logic [31:0]      HOST_CHK_IN,
    output logic             INIT_STR_OUT,
    output logic [31:0]      INIT_DAT_OUT,
    output logic             INIT_VLD_OUT,
    output logic             CPU_RST_OUT,
    output logic             STA_BUSY_OUT,
    output logic             STA_DONE_OUT,
    output logic             STA_ERR_OUT,
    output logic [P_ADR:0]   STA_WRDS_OUT,
    output logic [2:0]       DBG_STATE_OUT
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_LOAD = 3'd2,
        S_FIN  = 3'd3,
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    // Word count value meaning "RAM full"; one more word would overflow.
    localparam logic [P_ADR:0] C_CAP = {1'b1, {P_ADR{1'b0}}};

    state_t         state_q;
    logic [1:0]     bcnt_q;
    logic [31:0]    asm_q;

    logic [31:0]    asm_nxt;
    logic           word_full;
    logic           pad_req;
    logic           wr_req;
    logic [31:0]    wr_word;
    logic           cap_hit;

`ifdef PRT_DP_PM_LDR_CHK_EN
    logic [31:0]    chk_q;
    logic [31:0]    chk_exp_q;
`else
    logic           unused_chk;
    assign unused_chk = ^HOST_CHK_IN;
`endif

    assign DBG_STATE_OUT = state_q;

    // Byte insertion and word-write decision for the current LOAD cycle.
    always_comb begin
        asm_nxt = asm_q;
        case (bcnt_q)
            2'd0:    asm_nxt[7:0]   = HOST_DAT_IN;
            2'd1:    asm_nxt[15:8]  = HOST_DAT_IN;
            2'd2:    asm_nxt[23:16] = HOST_DAT_IN;
            default: asm_nxt[31:24] = HOST_DAT_IN;
        endcase
        word_full = HOST_VLD_IN && (bcnt_q == 2'd3);
        // End of image with bytes still pending (after any same-cycle byte)
        // flushes a partial word; unfilled lanes are already zero.
        pad_req   = HOST_END_IN && (HOST_VLD_IN ? (bcnt_q != 2'd3) : (bcnt_q != 2'd0));
        wr_req    = word_full || pad_req;
        wr_word   = HOST_VLD_IN ? asm_nxt : asm_q;
        cap_hit   = (STA_WRDS_OUT == C_CAP);
    end

    // Loader FSM with all outputs registered.
    always_ff @(posedge CLK_IN) begin
        if (RST_IN) begin
            state_q      <= S_IDLE;
            bcnt_q       <= '0;
            asm_q        <= '0;
            HOST_RDY_OUT <= 1'b0;
            INIT_STR_OUT <= 1'b0;
            INIT_DAT_OUT <= '0;
            INIT_VLD_OUT <= 1'b0;
            CPU_RST_OUT  <= 1'b1;
            STA_BUSY_OUT <= 1'b0;
            STA_DONE_OUT <= 1'b0;
            STA_ERR_OUT  <= 1'b0;
            STA_WRDS_OUT <= '0;
`ifdef PRT_DP_PM_LDR_CHK_EN
            chk_q        <= '0;
            chk_exp_q    <= '0;
`endif
        end else begin
            INIT_STR_OUT <= 1'b0;
            INIT_VLD_OUT <= 1'b0;
            if (HOST_STR_IN) begin
                // Start or abort: counters are cleared on entry so they
                // already read zero while CLR is visible.
                state_q      <= S_CLR;
                INIT_STR_OUT <= 1'b1;
                CPU_RST_OUT  <= 1'b1;
                STA_BUSY_OUT <= 1'b1;
                STA_DONE_OUT <= 1'b0;
                STA_ERR_OUT  <= 1'b0;
                HOST_RDY_OUT <= 1'b0;
                STA_WRDS_OUT <= '0;
                bcnt_q       <= '0;
                asm_q        <= '0;
`ifdef PRT_DP_PM_LDR_CHK_EN
                chk_q        <= '0;
`endif
            end else begin
                case (state_q)
                    S_IDLE: begin
                        CPU_RST_OUT  <= 1'b0;
                        HOST_RDY_OUT <= 1'b0;
                    end
                    S_CLR: begin
                        state_q      <= S_LOAD;
                        HOST_RDY_OUT <= 1'b1;
                    end
                    S_LOAD: begin
                        if (HOST_VLD_IN) begin
                            bcnt_q <= bcnt_q + 2'd1;
                            asm_q  <= word_full ? '0 : asm_nxt;
                        end
                        if (wr_req) begin
                            if (cap_hit) begin
                                // RAM already full: drop the word and fail.
                                state_q      <= S_ERR;
                                STA_ERR_OUT  <= 1'b1;
                                STA_BUSY_OUT <= 1'b0;
                                HOST_RDY_OUT <= 1'b0;
                            end else begin
                                INIT_VLD_OUT <= 1'b1;
                                INIT_DAT_OUT <= wr_word;
                                STA_WRDS_OUT <= STA_WRDS_OUT + 1'b1;
`ifdef PRT_DP_PM_LDR_CHK_EN
                                chk_q        <= chk_q + wr_word;
`endif
                            end
                        end
                        if (HOST_END_IN && !(wr_req && cap_hit)) begin
                            state_q      <= S_FIN;
                            HOST_RDY_OUT <= 1'b0;
`ifdef PRT_DP_PM_LDR_CHK_EN
                            chk_exp_q    <= HOST_CHK_IN;
`endif
                        end
                    end
                    S_FIN: begin
                        STA_BUSY_OUT <= 1'b0;
`ifdef PRT_DP_PM_LDR_CHK_EN
                        if (chk_q != chk_exp_q) begin
                            state_q     <= S_ERR;
                            STA_ERR_OUT <= 1'b1;
                        end else begin
                            state_q      <= S_DONE;
                            STA_DONE_OUT <= 1'b1;
                            CPU_RST_OUT  <= 1'b0;
                        end
`else
                        state_q      <= S_DONE;
                        STA_DONE_OUT <= 1'b1;
                        CPU_RST_OUT  <= 1'b0;
`endif
                    end
                    default: begin
                        // DONE and ERR hold until a new start pulse.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prt_dp_pm_ldr.sv
// tb_prt_dp_pm_ldr -- directed bench for prt_dp_pm_ldr (P_ADR=2).
// A per-cycle vector table covers the basic load; hand sequences cover
// partial word, overflow, abort/restart, mid-load reset and checksum.

module tb_prt_dp_pm_ldr;

    localparam int P_ADR = 2;

    logic           clk_in = 1'b0;
    logic           rst_in = 1'b1;
    logic           host_str = 1'b0;
    logic [7:0]     host_dat = '0;
    logic           host_vld = 1'b0;
    logic           host_rdy;
    logic           host_end = 1'b0;
    logic [31:0]    host_chk = '0;
    logic           init_str;
    logic [31:0]    init_dat;
    logic           init_vld;
    logic           cpu_rst;
    logic           sta_busy;
    logic           sta_done;
    logic           sta_err;
    logic [P_ADR:0] sta_wrds;
    logic [2:0]     dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int vld_cnt  = 0;
    logic [31:0] exp_q[$];

    // {init_str, init_vld, init_dat, cpu_rst, rdy, busy, done, err, wrds}
    typedef logic [41:0] outv_t;

    typedef struct {
        logic       str;
        logic       vld;
        logic [7:0] dat;
        logic       endp;
        outv_t      exp;
    } vec_t;

    vec_t vecs[14];

    prt_dp_pm_ldr #(.P_ADR(P_ADR)) dut (
        .CLK_IN        (clk_in),
        .RST_IN        (rst_in),
        .HOST_STR_IN   (host_str),
        .HOST_DAT_IN   (host_dat),
        .HOST_VLD_IN   (host_vld),
        .HOST_RDY_OUT  (host_rdy),
        .HOST_END_IN   (host_end),
        .HOST_CHK_IN   (host_chk),
        .INIT_STR_OUT  (init_str),
        .INIT_DAT_OUT  (init_dat),
        .INIT_VLD_OUT  (init_vld),
        .CPU_RST_OUT   (cpu_rst),
        .STA_BUSY_OUT  (sta_busy),
        .STA_DONE_OUT  (sta_done),
        .STA_ERR_OUT   (sta_err),
        .STA_WRDS_OUT  (sta_wrds),
        .DBG_STATE_OUT (dbg_state)
    );

    // Clock.
    always #5 clk_in = ~clk_in;

    // Scoreboard: every RAM write must match the next expected word.
    always @(negedge clk_in) begin
        if (init_vld) begin
            vld_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL init_word: unexpected write %h, none expected", init_dat);
            end else begin
                logic [31:0] w;
                w = exp_q.pop_front();
                if (init_dat !== w) begin
                    n_fail++;
                    $display("FAIL init_word: got %h want %h", init_dat, w);
                end
            end
        end
    end

    function automatic outv_t ov(input logic is, iv, input logic [31:0] id,
                                 input logic cpu, rdy, busy, done, err,
                                 input logic [2:0] w);
        return {is, iv, id, cpu, rdy, busy, done, err, w};
    endfunction

    function automatic vec_t mk(input logic s, vl, input logic [7:0] d,
                                input logic e, input outv_t x);
        vec_t r;
        r.str = s; r.vld = vl; r.dat = d; r.endp = e; r.exp = x;
        return r;
    endfunction

    function automatic outv_t act();
        return {init_str, init_vld, init_dat, cpu_rst, host_rdy, sta_busy,
                sta_done, sta_err, sta_wrds};
    endfunction

    task automatic step(input logic s, vl, input logic [7:0] d, input logic e);
        host_str = s; host_vld = vl; host_dat = d; host_end = e;
        @(posedge clk_in);
        #1;
        host_str = 1'b0; host_vld = 1'b0; host_end = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic check(input string name, input logic [41:0] got, want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        exp_q.push_back(w);
    endtask

    initial begin
        // Basic load table: inputs this cycle, outputs after the edge.
        vecs[0]  = mk(1, 0, 8'h00, 0, ov(1, 0, 32'h0, 1, 0, 1, 0, 0, 3'd0));
        vecs[1]  = mk(0, 0, 8'h00, 0, ov(0, 0, 32'h0, 1, 1, 1, 0, 0, 3'd0));
        vecs[2]  = mk(0, 1, 8'h01, 0, ov(0, 0, 32'h0, 1, 1, 1, 0, 0, 3'd0));
        vecs[3]  = mk(0, 1, 8'h02, 0, ov(0, 0, 32'h0, 1, 1, 1, 0, 0, 3'd0));
        vecs[4]  = mk(0, 1, 8'h03, 0, ov(0, 0, 32'h0, 1, 1, 1, 0, 0, 3'd0));
        vecs[5]  = mk(0, 1, 8'h04, 0, ov(0, 1, 32'h04030201, 1, 1, 1, 0, 0, 3'd1));
        vecs[6]  = mk(0, 1, 8'h05, 0, ov(0, 0, 32'h04030201, 1, 1, 1, 0, 0, 3'd1));
        vecs[7]  = mk(0, 0, 8'h00, 0, ov(0, 0, 32'h04030201, 1, 1, 1, 0, 0, 3'd1));
        vecs[8]  = mk(0, 1, 8'h06, 0, ov(0, 0, 32'h04030201, 1, 1, 1, 0, 0, 3'd1));
        vecs[9]  = mk(0, 1, 8'h07, 0, ov(0, 0, 32'h04030201, 1, 1, 1, 0, 0, 3'd1));
        vecs[10] = mk(0, 1, 8'h08, 0, ov(0, 1, 32'h08070605, 1, 1, 1, 0, 0, 3'd2));
        vecs[11] = mk(0, 0, 8'h00, 1, ov(0, 0, 32'h08070605, 1, 0, 1, 0, 0, 3'd2));
        vecs[12] = mk(0, 0, 8'h00, 0, ov(0, 0, 32'h08070605, 0, 0, 0, 1, 0, 3'd2));
        vecs[13] = mk(0, 1, 8'h55, 1, ov(0, 0, 32'h08070605, 0, 0, 0, 1, 0, 3'd2));

        // Reset state.
        rst_in = 1'b1;
        idle(2);
        check("reset_state", act(), ov(0, 0, 32'h0, 1, 0, 0, 0, 0, 3'd0));
        rst_in = 1'b0;
        idle(1);
        check("idle_cpu_run", act(), ov(0, 0, 32'h0, 0, 0, 0, 0, 0, 3'd0));

        // Basic load via the vector table.
        push_word(32'h04030201);
        push_word(32'h08070605);
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].str, vecs[i].vld, vecs[i].dat, vecs[i].endp);
            check($sformatf("basic_row%0d", i), act(), vecs[i].exp);
        end

        // Partial word: END together with the fifth byte.
        step(1, 0, 8'h00, 0);
        idle(1);
        push_word(32'hDDCCBBAA);
        push_word(32'h000000EE);
        step(0, 1, 8'hAA, 0);
        step(0, 1, 8'hBB, 0);
        step(0, 1, 8'hCC, 0);
        step(0, 1, 8'hDD, 0);
        step(0, 1, 8'hEE, 1);
        check("partial_pad", act(), ov(0, 1, 32'h000000EE, 1, 0, 1, 0, 0, 3'd2));
        idle(1);
        check("partial_done", act(), ov(0, 0, 32'h000000EE, 0, 0, 0, 1, 0, 3'd2));

        // Overflow: 20 bytes into a 4-word RAM.
        step(1, 0, 8'h00, 0);
        idle(1);
        vld_cnt = 0;
        push_word(32'h03020100);
        push_word(32'h07060504);
        push_word(32'h0B0A0908);
        push_word(32'h0F0E0D0C);
        for (int i = 0; i < 20; i++) begin
            logic [7:0] b;
            b = 8'(i);
            step(0, 1, b, 0);
        end
        check("ovf_err", act(), ov(0, 0, 32'h0F0E0D0C, 1, 0, 0, 0, 1, 3'd4));
        step(0, 1, 8'h99, 1);
        idle(2);
        check("ovf_hold", act(), ov(0, 0, 32'h0F0E0D0C, 1, 0, 0, 0, 1, 3'd4));
        check("ovf_pulses", 42'(vld_cnt), 42'd4);

        // Abort and restart.
        step(1, 0, 8'h00, 0);
        idle(1);
        push_word(32'h24232221);
        for (int i = 0; i < 6; i++) begin
            logic [7:0] b;
            b = 8'h21 + 8'(i);
            step(0, 1, b, 0);
        end
        step(1, 1, 8'h77, 1);
        check("abort_clr", act(), ov(1, 0, 32'h24232221, 1, 0, 1, 0, 0, 3'd0));
        idle(1);
        push_word(32'h14131211);
        step(0, 1, 8'h11, 0);
        step(0, 1, 8'h12, 0);
        step(0, 1, 8'h13, 0);
        step(0, 1, 8'h14, 0);
        step(0, 0, 8'h00, 1);
        check("abort_fin", act(), ov(0, 0, 32'h14131211, 1, 0, 1, 0, 0, 3'd1));
        idle(1);
        check("abort_done", act(), ov(0, 0, 32'h14131211, 0, 0, 0, 1, 0, 3'd1));

        // Mid-load reset after three bytes.
        step(1, 0, 8'h00, 0);
        idle(1);
        step(0, 1, 8'h31, 0);
        step(0, 1, 8'h32, 0);
        step(0, 1, 8'h33, 0);
        rst_in = 1'b1;
        step(0, 1, 8'h34, 0);
        rst_in = 1'b0;
        check("midrst_state", act(), ov(0, 0, 32'h0, 1, 0, 0, 0, 0, 3'd0));
        for (int i = 0; i < 5; i++) step(0, 1, 8'h40, (i == 4));
        idle(1);
        check("midrst_ignore", act(), ov(0, 0, 32'h0, 0, 0, 0, 0, 0, 3'd0));

        // Checksum: words 1 and FFFFFFFF sum to 0.
        for (int pass = 0; pass < 2; pass++) begin
            step(1, 0, 8'h00, 0);
            idle(1);
            push_word(32'h00000001);
            push_word(32'hFFFFFFFF);
            step(0, 1, 8'h01, 0);
            step(0, 1, 8'h00, 0);
            step(0, 1, 8'h00, 0);
            step(0, 1, 8'h00, 0);
            for (int i = 0; i < 4; i++) step(0, 1, 8'hFF, 0);
            host_chk = (pass == 0) ? 32'h0 : 32'h1;
            step(0, 0, 8'h00, 1);
            host_chk = 32'h0;
            check($sformatf("chk%0d_fin", pass), act(),
                  ov(0, 0, 32'hFFFFFFFF, 1, 0, 1, 0, 0, 3'd2));
            idle(1);
`ifdef PRT_DP_PM_LDR_CHK_EN
            if (pass == 0)
                check("chk0_end", act(), ov(0, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 3'd2));
            else
                check("chk1_end", act(), ov(0, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 1, 3'd2));
`else
            check($sformatf("chk%0d_end", pass), act(),
                  ov(0, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 3'd2));
`endif
        end

        idle(2);
        check("exp_q_empty", 42'(exp_q.size()), 42'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
